// File: rtl/pwm_capture.sv
// PWM input decoder: measures period and high time of pwm_i and reports a 10-bit duty code.
// Optional glitch filter ahead of the edge detector: define PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
    parameter int CNT_W    = 19,
    parameter int TIMEOUT  = 500000,
    parameter int FILT_LEN = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             acc_en_i,
    input  logic             pwm_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_time_o,
    output logic [9:0]       duty_o,
    output logic             valid_o,
    output logic             stuck_o,
    output logic             overrun_o
);
    localparam int NUM_W = CNT_W + 10;
    localparam logic [CNT_W-1:0] TO_SAT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_PRE = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    if (FILT_LEN < 1 || TIMEOUT < 12) begin : g_bad_cfg
        $error("pwm_capture: FILT_LEN must be >= 1 and TIMEOUT >= 12");
    end

    logic sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    logic level, rise, fall;

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);
    logic            filt_q, filt_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;

    // The filtered level only follows the synced input after FILT_LEN consecutive disagreeing clocks.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == FC_W'(FILT_LEN - 1)) filt_d = sync2_q;
            else                               fcnt_d = fcnt_q + FC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    always_comb begin
        sync1_d = pwm_i;
        sync2_d = sync1_q;
        hist_d  = level;
    end

    assign rise = level & ~hist_q;
    assign fall = ~level & hist_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] per_hold_q, per_hold_d, hi_hold_q, hi_hold_d;
    logic [NUM_W-1:0] rem_q, rem_d, den_q, den_d;
    logic [9:0]       quot_q, quot_d;
    logic [3:0]       step_q, step_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic [9:0]       duty_q, duty_d;
    logic             valid_q, valid_d, stuck_q, stuck_d, ovr_q, ovr_d;
    logic             start, drop, tmo;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_cap_d   = hi_cap_q;
        per_hold_d = per_hold_q;
        hi_hold_d  = hi_hold_q;
        rem_d      = rem_q;
        den_d      = den_q;
        quot_d     = quot_q;
        step_d     = step_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        period_d   = period_q;
        high_d     = high_q;
        duty_d     = duty_q;
        valid_d    = 1'b0;
        stuck_d    = stuck_q;
        ovr_d      = ovr_q;
        start      = 1'b0;
        drop       = 1'b0;
        tmo        = 1'b0;

        if (!acc_en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else begin
            cnt_d = (cnt_q == TO_SAT) ? cnt_q : cnt_q + CNT_W'(1);
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_W'(1);
                    end else if (fall) begin
                        cnt_d = CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        hi_cap_d = cnt_q;
                        state_d  = LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        cnt_d   = CNT_W'(1);
                        state_d = HIGH;
                        if (busy_q) drop  = 1'b1;
                        else        start = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Counter saturates at TIMEOUT, so the watchdog fires once per quiet stretch.
            if (!rise && !fall && cnt_q == TO_PRE) begin
                tmo     = 1'b1;
                state_d = IDLE;
            end

            if (busy_q) begin
                if (rem_q >= den_q) begin
                    rem_d  = rem_q - den_q;
                    quot_d = {quot_q[8:0], 1'b1};
                end else begin
                    quot_d = {quot_q[8:0], 1'b0};
                end
                den_d  = den_q >> 1;
                step_d = step_q + 4'd1;
                if (step_q == 4'd9) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end

            // hi*1023 as hi*1024 - hi; denominator pre-shifted for the quotient MSB.
            if (start) begin
                rem_d      = {hi_cap_q, 10'd0} - {10'd0, hi_cap_q};
                den_d      = {1'b0, cnt_q, 9'd0};
                quot_d     = '0;
                step_d     = '0;
                busy_d     = 1'b1;
                per_hold_d = cnt_q;
                hi_hold_d  = hi_cap_q;
            end

            if (tmo) begin
                period_d = '0;
                high_d   = '0;
                duty_d   = level ? 10'd1023 : 10'd0;
                valid_d  = 1'b1;
            end else if (done_q) begin
                period_d = per_hold_q;
                high_d   = hi_hold_q;
                duty_d   = quot_q;
                valid_d  = 1'b1;
            end

            if (clear_i) begin
                stuck_d = 1'b0;
                ovr_d   = 1'b0;
            end
            if (tmo)  stuck_d = 1'b1;
            if (drop) ovr_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hist_q     <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_cap_q   <= '0;
            per_hold_q <= '0;
            hi_hold_q  <= '0;
            rem_q      <= '0;
            den_q      <= '0;
            quot_q     <= '0;
            step_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            period_q   <= '0;
            high_q     <= '0;
            duty_q     <= '0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            hist_q     <= hist_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_cap_q   <= hi_cap_d;
            per_hold_q <= per_hold_d;
            hi_hold_q  <= hi_hold_d;
            rem_q      <= rem_d;
            den_q      <= den_d;
            quot_q     <= quot_d;
            step_q     <= step_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            period_q   <= period_d;
            high_q     <= high_d;
            duty_q     <= duty_d;
            valid_q    <= valid_d;
            stuck_q    <= stuck_d;
            ovr_q      <= ovr_d;
        end
    end

    assign period_o    = period_q;
    assign high_time_o = high_q;
    assign duty_o      = duty_q;
    assign valid_o     = valid_q;
    assign stuck_o     = stuck_q;
    assign overrun_o   = ovr_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected reports, a negedge monitor checks them.
module tb_pwm_capture;
    localparam int CNT_W = 19;
    localparam int TMO   = 1500;

    logic             clk = 1'b0;
    logic             rstn, acc_en, pwm, clear;
    logic [CNT_W-1:0] period_o, high_time_o;
    logic [9:0]       duty_o;
    logic             valid_o, stuck_o, overrun_o;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO), .FILT_LEN(4)) dut (
        .clk_i(clk), .rstn_i(rstn), .acc_en_i(acc_en), .pwm_i(pwm), .clear_i(clear),
        .period_o(period_o), .high_time_o(high_time_o), .duty_o(duty_o),
        .valid_o(valid_o), .stuck_o(stuck_o), .overrun_o(overrun_o)
    );

    typedef struct {
        int tag;
        int per;
        int hi;
        int duty;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  e_cur;
    int    n_pass = 0;
    int    n_total = 0;
    int    tag = 0;
    int    req_id = 0;
    int    seen_id = 0;
    int    req_kind = 0;
    bit    req_stuck, req_ovr;
    string req_name = "";

    // Monitor: sole owner of the pass/total counters.
    always @(negedge clk) begin
        if (valid_o) begin
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_valid: got per=%0d hi=%0d duty=%0d, none expected",
                         period_o, high_time_o, duty_o);
            end else begin
                e_cur = sb_q.pop_front();
                if (int'(period_o) == e_cur.per && int'(high_time_o) == e_cur.hi && int'(duty_o) == e_cur.duty)
                    n_pass++;
                else
                    $display("FAIL report_%0d: got per=%0d hi=%0d duty=%0d, expected per=%0d hi=%0d duty=%0d",
                             e_cur.tag, period_o, high_time_o, duty_o, e_cur.per, e_cur.hi, e_cur.duty);
            end
        end
        if (req_id != seen_id) begin
            seen_id = req_id;
            n_total++;
            case (req_kind)
                0: begin
                    if (stuck_o == req_stuck && overrun_o == req_ovr) n_pass++;
                    else $display("FAIL %s: got stuck=%0d overrun=%0d, expected stuck=%0d overrun=%0d",
                                  req_name, stuck_o, overrun_o, req_stuck, req_ovr);
                end
                1: begin
                    if (period_o == '0 && high_time_o == '0 && duty_o == '0 && !valid_o && !stuck_o && !overrun_o)
                        n_pass++;
                    else $display("FAIL %s: got per=%0d hi=%0d duty=%0d valid=%0d stuck=%0d overrun=%0d, expected all 0",
                                  req_name, period_o, high_time_o, duty_o, valid_o, stuck_o, overrun_o);
                end
                default: begin
                    if (sb_q.size() == 0) n_pass++;
                    else $display("FAIL drain: got %0d reports still outstanding, expected 0", sb_q.size());
                    $display("%0d/%0d checks passed", n_pass, n_total);
                    $finish;
                end
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int kind, input bit s, input bit o, input string nm);
        req_kind  = kind;
        req_stuck = s;
        req_ovr   = o;
        req_name  = nm;
        req_id++;
    endtask

    task automatic expect_rep(input int p, input int h, input int d);
        exp_t e;
        e.tag = tag; e.per = p; e.hi = h; e.duty = d;
        sb_q.push_back(e);
        tag++;
    endtask

    // One PWM period; when rep is set the period is expected to be reported once the next rise closes it.
    task automatic pulse(input int h, input int p, input bit rep, input int d, input bit clr);
        if (rep) expect_rep(p, h, d);
        pwm   = 1'b1;
        clear = clr;
        cyc();
        clear = 1'b0;
        repeat (h - 1) cyc();
        pwm = 1'b0;
        repeat (p - h) cyc();
    endtask

    task automatic settle();
        pwm = 1'b0;
        repeat (30) cyc();
        acc_en = 1'b0;
        repeat (2) cyc();
        acc_en = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; acc_en = 1'b1; pwm = 1'b0; clear = 1'b0;
        repeat (3) cyc();
        req(1, 0, 0, "reset_state");
        cyc();
        rstn = 1'b1;
        cyc();

        // T1: 400/100 -> 255
        for (int i = 0; i < 4; i++) pulse(100, 400, 1, 255, 0);
        pulse(100, 400, 0, 0, 0);
        settle();

        // T2: near-full and near-empty duty
`ifdef PWM_CAPTURE_FILTER_EN
        pulse(996, 1000, 1, 1018, 0);
        pulse(1019, 1023, 1, 1019, 0);
        pulse(4, 1000, 1, 4, 0);
`else
        pulse(999, 1000, 1, 1021, 0);
        pulse(1022, 1023, 1, 1022, 0);
        pulse(1, 1000, 1, 1, 0);
`endif
        pulse(4, 20, 0, 0, 0);
        settle();

        // T3: stuck high then stuck low
        expect_rep(0, 0, 1023);
        pwm = 1'b1;
        repeat (TMO + 100) cyc();
        req(0, 1, 0, "stuck_high_flag");
        expect_rep(0, 0, 0);
        pwm = 1'b0;
        repeat (TMO + 100) cyc();
        req(0, 1, 0, "stuck_low_flag");
        cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        cyc();
        req(0, 0, 0, "stuck_cleared");
        cyc();
        settle();

        // T4: period 8 overruns every other measurement, then period 12 after clear
        pulse(4, 8, 1, 511, 0);
        pulse(4, 8, 0, 0, 0);
        pulse(4, 8, 1, 511, 0);
        pulse(4, 8, 0, 0, 0);
        pulse(4, 12, 1, 341, 0);
        req(0, 0, 1, "overrun_set");
        pulse(4, 12, 1, 341, 1);
        pulse(4, 12, 1, 341, 0);
        pulse(4, 12, 0, 0, 0);
        req(0, 0, 0, "overrun_cleared");
        cyc();
        settle();

        // T5: disable mid-HIGH discards the partial period
        pulse(100, 400, 1, 255, 0);
        pwm = 1'b1;
        repeat (50) cyc();
        acc_en = 1'b0;
        repeat (10) cyc();
        acc_en = 1'b1;
        repeat (40) cyc();
        pwm = 1'b0;
        repeat (300) cyc();
        pulse(150, 300, 1, 511, 0);
        pulse(150, 300, 0, 0, 0);
        settle();

`ifdef PWM_CAPTURE_FILTER_EN
        // T6: 2-cycle glitch in the low phase must not disturb the measurement
        expect_rep(400, 100, 255);
        pwm = 1'b1;
        repeat (100) cyc();
        pwm = 1'b0;
        repeat (150) cyc();
        pwm = 1'b1;
        repeat (2) cyc();
        pwm = 1'b0;
        repeat (148) cyc();
        pulse(100, 400, 0, 0, 0);
        settle();
`endif

        // Reset in the middle of a high phase
        pwm = 1'b1;
        repeat (50) cyc();
        rstn = 1'b0;
        cyc();
        req(1, 0, 0, "reset_mid_period");
        cyc();
        rstn = 1'b1;
        pwm = 1'b0;
        repeat (50) cyc();
        req(2, 0, 0, "drain");
    end
endmodule
